// File: rtl/echo_delay_controller.sv
// Delay-line SRAM sequencer for the echo path: zero-fills the memory after reset, then
// per audio frame reads the sample written `delay` frames ago and writes the new one.
module echo_delay_controller #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     ADCLRCK,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic        [ADDR_W-1:0] delay,
    input  logic signed [DATA_W-1:0] Q,
    output logic signed [DATA_W-1:0] D,
    output logic        [ADDR_W-1:0] read_address,
    output logic        [ADDR_W-1:0] write_address,
    output logic                     W_E,
    output logic signed [DATA_W-1:0] delayed_out,
    output logic                     delayed_valid,
    output logic                     init_done,
    output logic                     sample_miss
);

    localparam logic [2:0] RdLatCnt = 3'(RD_LAT);

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StIssue,
        StWait,
        StWrite
    } state_e;

    state_e                     state;
    logic        [ADDR_W:0]     clr_cnt;
    logic        [ADDR_W-1:0]   wr_ptr;
    logic        [2:0]          wait_cnt;
    logic signed [DATA_W-1:0]   sample_reg;
    logic                       s1, s2, s3;
    logic                       frame_edge;
    logic        [ADDR_W-1:0]   d_eff;

    always_comb begin
        frame_edge = s2 & ~s3;
        // A zero delay would read the slot being written this frame.
        d_eff = (delay == '0) ? ADDR_W'(1) : delay;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= StClear;
            clr_cnt       <= '0;
            wr_ptr        <= '0;
            wait_cnt      <= '0;
            sample_reg    <= '0;
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            D             <= '0;
            read_address  <= '0;
            write_address <= '0;
            W_E           <= 1'b0;
            delayed_out   <= '0;
            delayed_valid <= 1'b0;
            init_done     <= 1'b0;
            sample_miss   <= 1'b0;
        end else begin
            s1            <= ADCLRCK;
            s2            <= s1;
            s3            <= s2;
            W_E           <= 1'b0;
            delayed_valid <= 1'b0;
            sample_miss   <= 1'b0;
            unique case (state)
                StClear: begin
                    // Top bit of the counter marks that the last address has been written.
                    if (clr_cnt[ADDR_W]) begin
                        init_done <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        W_E           <= 1'b1;
                        D             <= '0;
                        write_address <= clr_cnt[ADDR_W-1:0];
                        clr_cnt       <= clr_cnt + 1'b1;
                    end
                end
                StIdle: begin
                    if (frame_edge) state <= StIssue;
                end
                StIssue: begin
                    sample_miss  <= frame_edge;
                    sample_reg   <= sample_in;
                    read_address <= wr_ptr - d_eff;
                    wait_cnt     <= 3'd1;
                    state        <= StWait;
                end
                StWait: begin
                    sample_miss <= frame_edge;
                    if (wait_cnt == RdLatCnt) begin
                        // Write strobe is set up here so W_E is high during the WRITE state.
                        delayed_out   <= Q;
                        delayed_valid <= 1'b1;
                        W_E           <= 1'b1;
                        write_address <= wr_ptr;
                        D             <= sample_reg;
                        state         <= StWrite;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                StWrite: begin
                    sample_miss <= frame_edge;
                    wr_ptr      <= wr_ptr + 1'b1;
                    state       <= StIdle;
                end
                default: state <= StClear;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_controller.sv
// Randomized self-checking bench for echo_delay_controller with a simple SRAM model and
// a frame-history reference model (expected echo = sample from d_eff frames earlier).
module tb_echo_delay_controller;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              adclrck = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [ADDR_W-1:0] delay = '0;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] read_address;
    logic [ADDR_W-1:0] write_address;
    logic              w_e;
    logic [DATA_W-1:0] delayed_out;
    logic              delayed_valid;
    logic              init_done;
    logic              sample_miss;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] hist [$];

    always #5 clk = ~clk;

    echo_delay_controller #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .ADCLRCK      (adclrck),
        .sample_in    (sample_in),
        .delay        (delay),
        .Q            (q),
        .D            (d),
        .read_address (read_address),
        .write_address(write_address),
        .W_E          (w_e),
        .delayed_out  (delayed_out),
        .delayed_valid(delayed_valid),
        .init_done    (init_done),
        .sample_miss  (sample_miss)
    );

    // SRAM: Q is valid on the second cycle that read_address is held.
    initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'hdead;
    always @(posedge clk) begin
        q_reg <= mem[read_address];
        if (w_e) mem[write_address] <= d;
    end
    assign q = q_reg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Holds reset, checks reset outputs, releases, then checks the full zero-fill sweep.
    task automatic reset_fill();
        reset   = 1'b1;
        adclrck = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(w_e), 0);
        check("rst_valid", 32'(delayed_valid), 0);
        check("rst_init", 32'(init_done), 0);
        check("rst_out", 32'(delayed_out), 0);
        check("rst_bus", {d, write_address, read_address, 7'd0, sample_miss}, 0);
        reset = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            check("fill_we", 32'(w_e), 1);
            check("fill_addr", 32'(write_address), 32'(i));
            check("fill_d", 32'(d), 0);
            check("fill_init", 32'(init_done), 0);
            check("fill_miss", 32'(sample_miss), 0);
            // Frame edges during the fill must be ignored.
            adclrck = (i < 10) && ((i & 2) != 0);
        end
        @(negedge clk);
        check("fill_done_init", 32'(init_done), 1);
        check("fill_done_we", 32'(w_e), 0);
        adclrck = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_fill_we", 32'(w_e), 0);
        end
        hist.delete();
    endtask

    // One frame; with overrun a second edge lands 2 cycles after the first.
    task automatic frame(input logic [DATA_W-1:0] s, input logic [ADDR_W-1:0] dl,
                         input bit overrun);
        int we_cnt = 0, v_cnt = 0, m_cnt = 0, n, de, lat = 99;
        logic [DATA_W-1:0] exp;
        n   = hist.size();
        de  = (dl == 0) ? 1 : int'(dl);
        exp = (n >= de) ? hist[n-de] : '0;
        sample_in = s;
        delay     = dl;
        adclrck   = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (overrun && cyc == 0) adclrck = 1'b0;
            if (overrun && cyc == 1) adclrck = 1'b1;
            if (cyc == 8) begin
                adclrck = 1'b0;
                delay   = 4'($urandom);
            end
            if (w_e) begin
                we_cnt++;
                check("wr_addr", 32'(write_address), 32'(n % int'(DEPTH)));
                check("wr_data", 32'(d), 32'(s));
                check("rd_addr", 32'(read_address), 32'((n - de + int'(DEPTH)) % int'(DEPTH)));
            end
            if (delayed_valid) begin
                v_cnt++;
                lat = cyc + 1;
                check("delayed_out", 32'(delayed_out), 32'(exp));
            end
            if (sample_miss) m_cnt++;
        end
        check("we_count", 32'(we_cnt), 1);
        check("valid_count", 32'(v_cnt), 1);
        check("miss_count", 32'(m_cnt), overrun ? 1 : 0);
        check("latency_ok", 32'(lat <= int'(RD_LAT) + 5), 1);
        check("out_hold", 32'(delayed_out), 32'(exp));
        hist.push_back(s);
    endtask

    initial begin
        reset_fill();

        for (int k = 1; k <= 5; k++) frame(16'(k * 100), 4'd3, 1'b0);

        reset_fill();
        frame(16'd7, 4'd0, 1'b0);
        frame(16'd8, 4'd0, 1'b0);

        reset_fill();
        for (int k = 0; k < 20; k++) frame(16'(k + 1), 4'd2, 1'b0);

        for (int k = 0; k < 30; k++) frame(16'($urandom), 4'($urandom_range(0, 15)), 1'b0);

        frame(16'h8001, 4'd1, 1'b1);
        frame(16'h1234, 4'd1, 1'b0);

        // Reset while the frame is in the read-wait phase.
        adclrck = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_abort_valid", 32'(delayed_valid), 0);
        reset   = 1'b1;
        adclrck = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(w_e), 0);
        check("abort_valid", 32'(delayed_valid), 0);
        check("abort_init", 32'(init_done), 0);
        reset_fill();
        frame(16'hfff0, 4'd5, 1'b0);
        frame(16'h0042, 4'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
